alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Operand-fetch stage directly upstream of the alu (a, b, sel -> y).
//   Holds the 2R/1W integer register file and reads rs1/rs2.
//   Selects an immediate for operand b when requested.
//   Registers a, b and sel into a one-entry pipeline slot with valid/ready handshakes on both sides.
// PARAMETERS
//   DATA_W  32  operand/register width; must match the alu's a/b/y width
//   ADDR_W  5   register address width; register count NREGS = 2**ADDR_W
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       upstream instruction fields valid
//   in_ready   out  1       stage can accept this cycle
//   rs1_addr   in   ADDR_W  source register for operand a
//   rs2_addr   in   ADDR_W  source register for operand b
//   imm        in   DATA_W  immediate value
//   use_imm    in   1       1: b = imm; 0: b = rf[rs2_addr]
//   sel_in     in   3       alu op code, passed through (000 add, 001 sub, 010 and, 011 or, 100 xor)
//   rd_in      in   ADDR_W  destination register, passed through
//   flush      in   1       synchronous kill of the held entry
//   wb_en      in   1       register-file write enable
//   wb_addr    in   ADDR_W  write address
//   wb_data    in   DATA_W  write data
//   out_valid  out  1       a/b/sel/rd_out valid to the alu
//   out_ready  in   1       downstream accepts
//   a          out  DATA_W  alu operand a
//   b          out  DATA_W  alu operand b
//   sel        out  3       alu select
//   rd_out     out  ADDR_W  destination register
// BEHAVIOUR
// - Reset (rst=1, async): all rf entries = 0; out_valid = 0; a = b = 0; sel = 0; rd_out = 0.
// - Register 0 reads as 0 always. Writes to address 0 are ignored.
// - Writes take effect at the clk edge where wb_en = 1. Writes are ignored while rst = 1.
// - in_ready = !out_valid || out_ready. This is combinational; there is no input buffering.
// - Accept = in_valid && in_ready && !flush.
//   - On accept, the next edge loads:
//     a = rf[rs1_addr]; b = use_imm ? imm : rf[rs2_addr]; sel = sel_in; rd_out = rd_in.
//   - out_valid is set to 1 on that edge.
//   - Latency is 1 cycle from accept to out_valid.
// - If out_valid && out_ready && !accept, out_valid clears on the next edge.
//   a/b/sel/rd_out keep their last values.
// - Stall: while out_valid && !out_ready, all outputs hold stable.
//   A later rf write to rs1/rs2 does not alter the held a/b; operands are snapshotted at accept.
// - Back-to-back: out_ready = 1 with in_valid = 1 every cycle gives one transfer per cycle and no bubbles.
// - flush = 1 has priority over everything:
//   - out_valid clears on the next edge.
//   - Any same-cycle input is dropped.
//   - rf writes still occur.
// - Same-edge read/write of the same nonzero address: see CONFIGURATION.
// - Reset asserted mid-transfer drops the held entry immediately (out_valid falls asynchronously).
// CONFIGURATION
//   WB_BYPASS_EN defined:
//     - If wb_en && wb_addr == rsX_addr != 0 on an accept cycle, that operand captures wb_data
//       (write-before-read).
//     - The bypass to b applies only when use_imm = 0.
//   WB_BYPASS_EN undefined:
//     - The operand captures the pre-write rf value.
//     - The new value becomes visible to accepts in later cycles.
// TESTING
//   1 Reset:
//     - Assert rst mid-simulation with out_valid=1 -> out_valid=0 and a=b=sel=rd_out=0 before the next edge.
//     - Any read afterwards returns 0.
//   2 Add path:
//     - Write r1=15, r2=5; accept rs1=1, rs2=2, use_imm=0, sel_in=000, rd_in=3.
//     - Next cycle: out_valid=1, a=15, b=5, sel=000, rd_out=3; alu y=20.
//   3 Immediate / x0:
//     - Accept rs1=0, imm=32'hFFFF0000, use_imm=1, sel_in=010 -> a=0, b=FFFF0000.
//     - A wb_en write of 32'h1234 to addr 0 leaves a later read of r0 = 0.
//   4 Stall:
//     - Hold out_ready=0 for 3 cycles after accept (r1=32'hAAAA0000) and write r1=1 during the stall.
//     - a stays AAAA0000 and in_ready=0.
//     - Release -> one transfer, then out_valid=0.
//   5 Flush:
//     - flush=1 together with in_valid=1 and out_valid=1 -> next cycle out_valid=0.
//     - The input is not captured.
//   6 Bypass:
//     - r4=7; same cycle wb_en, wb_addr=4, wb_data=9, accept rs1=4.
//     - Expect a=9 with WB_BYPASS_EN defined, a=7 without.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Brief    : Operand fetch ahead of the alu. Holds a 2R/1W register file,
//            picks rf or immediate for b, and registers a/b/sel/rd into a
//            one-entry slot with valid/ready on both sides.
//            Optional macro WB_BYPASS_EN forwards a same-cycle writeback
//            into the captured operands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [2:0]        sel_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [2:0]        sel,
    output logic [ADDR_W-1:0] rd_out
);

    localparam int c_NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] rf_q [c_NREGS];
    logic [DATA_W-1:0] rf_d [c_NREGS];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] rd_q, rd_d;

    logic              w_accept;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    assign in_ready = !out_valid_q || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != '0)) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Register 0 is forced to zero on read regardless of storage contents
    always_comb begin
        w_rs1_val = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
        w_rs2_val = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) begin
            w_rs1_val = wb_data;
        end
        if (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) begin
            w_rs2_val = wb_data;
        end
`endif
    end

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            a_d         = w_rs1_val;
            b_d         = use_imm ? imm : w_rs2_val;
            sel_d       = sel_in;
            rd_d        = rd_in;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                rf_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
        end else begin
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign sel       = sel_q;
    assign rd_out    = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Directed scoreboard bench for alu_operand_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_in, wb_addr, rd_out;
    logic [31:0] imm, wb_data, a, b;
    logic        use_imm, flush, wb_en, out_valid, out_ready;
    logic [2:0]  sel_in, sel;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic [31:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] c_BYP_A = 32'd9;
`else
    localparam logic [31:0] c_BYP_A = 32'd7;
`endif

    alu_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .imm(imm), .use_imm(use_imm), .sel_in(sel_in), .rd_in(rd_in),
        .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .sel(sel), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_y(logic [31:0] x, logic [31:0] z, logic [2:0] s);
        case (s)
            3'b000:  return x + z;
            3'b001:  return x - z;
            3'b010:  return x & z;
            3'b011:  return x | z;
            3'b100:  return x ^ z;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] ad, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = ad; wb_data = d;
    endtask

    task automatic req(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] im,
                       input logic ui, input logic [2:0] s, input logic [4:0] rd);
        in_valid = 1'b1; rs1_addr = r1; rs2_addr = r2; imm = im;
        use_imm = ui; sel_in = s; rd_in = rd;
    endtask

    task automatic push(input logic [31:0] ea, input logic [31:0] eb, input logic [2:0] es,
                        input logic [4:0] erd, input logic [31:0] ey);
        exp_t e;
        e.a = ea; e.b = eb; e.sel = es; e.rd = erd; e.y = ey;
        exp_q.push_back(e);
    endtask

    // Monitor: every downstream handshake pops one expected transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_a", {32'h0, a}, {32'h0, e.a});
                chk("xfer_b", {32'h0, b}, {32'h0, e.b});
                chk("xfer_sel", {61'h0, sel}, {61'h0, e.sel});
                chk("xfer_rd", {59'h0, rd_out}, {59'h0, e.rd});
                chk("xfer_y", {32'h0, alu_y(a, b, sel)}, {32'h0, e.y});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; imm = '0;
        use_imm = 1'b0; sel_in = '0; rd_in = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_a", {32'h0, a}, 64'd0);
        chk("rst_b", {32'h0, b}, 64'd0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);

        // Add path
        wr(5'd1, 32'd15); tick();
        wr(5'd2, 32'd5);  tick();
        wb_en = 1'b0;
        req(5'd1, 5'd2, 32'h0, 1'b0, 3'b000, 5'd3); push(32'd15, 32'd5, 3'b000, 5'd3, 32'd20);
        tick();
        in_valid = 1'b0;
        chk("add_out_valid", {63'h0, out_valid}, 64'd1);
        tick();
        chk("add_drain", {63'h0, out_valid}, 64'd0);

        // Immediate, x0 write ignored, back-to-back accepts
        wr(5'd0, 32'h1234);
        req(5'd0, 5'd0, 32'hFFFF0000, 1'b1, 3'b010, 5'd5); push(32'h0, 32'hFFFF0000, 3'b010, 5'd5, 32'h0);
        tick();
        wb_en = 1'b0;
        req(5'd0, 5'd0, 32'h0, 1'b0, 3'b011, 5'd6); push(32'h0, 32'h0, 3'b011, 5'd6, 32'h0);
        tick();
        chk("b2b_in_ready", {63'h0, in_ready}, 64'd1);
        req(5'd2, 5'd1, 32'h0, 1'b0, 3'b100, 5'd7); push(32'd5, 32'd15, 3'b100, 5'd7, 32'd10);
        tick();
        in_valid = 1'b0;
        tick();

        // Stall with write to the snapshotted source
        wr(5'd1, 32'hAAAA0000); tick();
        wb_en = 1'b0;
        out_ready = 1'b0;
        req(5'd1, 5'd2, 32'h0, 1'b0, 3'b001, 5'd8); push(32'hAAAA0000, 32'd5, 3'b001, 5'd8, 32'hAAA9FFFB);
        tick();
        in_valid = 1'b0;
        wr(5'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_en = 1'b0;
            chk("stall_valid", {63'h0, out_valid}, 64'd1);
            chk("stall_a", {32'h0, a}, 64'hAAAA0000);
            chk("stall_in_ready", {63'h0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release_clear", {63'h0, out_valid}, 64'd0);
        req(5'd1, 5'd0, 32'h0, 1'b0, 3'b100, 5'd9); push(32'd1, 32'h0, 3'b100, 5'd9, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();

        // Flush: kill held entry, drop same-cycle input, rf write still lands
        out_ready = 1'b0;
        req(5'd2, 5'd1, 32'h0, 1'b0, 3'b000, 5'd10);
        tick();
        chk("flush_pre_valid", {63'h0, out_valid}, 64'd1);
        flush = 1'b1; out_ready = 1'b1; wr(5'd5, 32'h55);
        req(5'd1, 5'd1, 32'h0, 1'b0, 3'b000, 5'd11);
        // Held entry would otherwise hand off at this edge; monitor must not see it
        out_ready = 1'b0;
        tick();
        chk("flush_kill", {63'h0, out_valid}, 64'd0);
        out_ready = 1'b1; wb_en = 1'b0;
        req(5'd1, 5'd1, 32'h0, 1'b0, 3'b000, 5'd12);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_drop_input", {63'h0, out_valid}, 64'd0);
        req(5'd5, 5'd0, 32'h0, 1'b0, 3'b011, 5'd13); push(32'h55, 32'h0, 3'b011, 5'd13, 32'h55);
        tick();
        in_valid = 1'b0;
        tick();

        // Same-edge write/read of r4
        wr(5'd4, 32'd7); tick();
        wr(5'd4, 32'd9);
        req(5'd4, 5'd4, 32'd3, 1'b1, 3'b000, 5'd14); push(c_BYP_A, 32'd3, 3'b000, 5'd14, c_BYP_A + 32'd3);
        tick();
        wb_en = 1'b0;
        req(5'd4, 5'd4, 32'h0, 1'b0, 3'b100, 5'd15); push(32'd9, 32'd9, 3'b100, 5'd15, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();

        // Asynchronous reset with a held entry
        out_ready = 1'b0;
        req(5'd4, 5'd2, 32'h0, 1'b0, 3'b001, 5'd16);
        tick();
        in_valid = 1'b0;
        chk("rst_pre_valid", {63'h0, out_valid}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'h0, out_valid}, 64'd0);
        chk("async_rst_a", {32'h0, a}, 64'd0);
        chk("async_rst_b", {32'h0, b}, 64'd0);
        chk("async_rst_sel", {61'h0, sel}, 64'd0);
        chk("async_rst_rd", {59'h0, rd_out}, 64'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        req(5'd4, 5'd2, 32'h0, 1'b0, 3'b000, 5'd17); push(32'h0, 32'h0, 3'b000, 5'd17, 32'h0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        chk("scoreboard_empty", {32'h0, exp_q.size()}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
